// File: rtl/sr_ff_bank.sv
// sr_ff_bank: bank of WIDTH clocked SR flip-flops with active-low S/R inputs.
// The forbidden S=R=0 input is resolved per MODE and reported through
// registered conflict flags and a saturating conflict counter.
module sr_ff_bank #(
    parameter int              WIDTH = 8,
    parameter int              MODE  = 0,
    parameter logic [WIDTH-1:0] INIT = '0,
    parameter int              CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] s_n,
    input  logic [WIDTH-1:0] r_n,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             chg,
    output logic             conflict,
    output logic [WIDTH-1:0] conflict_mask,
    output logic [CNT_W-1:0] conflict_cnt
);

    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_params
        $error("sr_ff_bank: WIDTH and CNT_W must both be at least 1");
    end

    // Out-of-range policies fall back to hold.
    localparam int MODE_EFF = (MODE >= 0 && MODE <= 3) ? MODE : 0;

    logic [WIDTH-1:0] q_q, q_d;
    logic             chg_q, chg_d;
    logic             conflict_q, conflict_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Next-state resolution for every bit plus the event flags and counter.
    always_comb begin
        q_d        = q_q;
        mask_d     = '0;
        conflict_d = 1'b0;
        cnt_d      = cnt_q;
        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                unique case ({s_n[i], r_n[i]})
                    2'b11: q_d[i] = q_q[i];
                    2'b01: q_d[i] = 1'b1;
                    2'b10: q_d[i] = 1'b0;
                    default: begin
                        case (MODE_EFF)
                            1:       q_d[i] = 1'b1;
                            2:       q_d[i] = 1'b0;
                            3:       q_d[i] = ~q_q[i];
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                endcase
            end
            mask_d     = ~s_n & ~r_n;
            conflict_d = |mask_d;
            if (conflict_d) begin
                cnt_d = sat_inc(cnt_q);
            end
        end
        // A clear beats a simultaneous increment and works even with en low.
        if (clr_cnt) begin
            cnt_d = '0;
        end
        chg_d = (q_d != q_q);
    end

    // State and flag registers; reset discards whatever input is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q        <= INIT;
            chg_q      <= 1'b0;
            conflict_q <= 1'b0;
            mask_q     <= '0;
            cnt_q      <= '0;
        end else begin
            q_q        <= q_d;
            chg_q      <= chg_d;
            conflict_q <= conflict_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
        end
    end

    assign q             = q_q;
    assign q_n           = ~q_q;
    assign chg           = chg_q;
    assign conflict      = conflict_q;
    assign conflict_mask = mask_q;
    assign conflict_cnt  = cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// tb_sr_ff_bank: four WIDTH=4 / CNT_W=2 banks, one per MODE, share the same
// stimulus; a reference model predicts each cycle's outputs into a queue and
// a monitor process compares them after every rising edge.
module tb_sr_ff_bank;

    localparam logic [3:0] INIT = 4'b0101;
    localparam int         NM   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic clr_cnt = 1'b0;
    logic [3:0] s_n = 4'hF;
    logic [3:0] r_n = 4'hF;

    logic [NM-1:0][3:0] q_o, qn_o, mask_o;
    logic [NM-1:0]      chg_o, conf_o;
    logic [NM-1:0][1:0] cnt_o;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NM; g++) begin : g_dut
        sr_ff_bank #(.WIDTH(4), .MODE(g), .INIT(INIT), .CNT_W(2)) u_dut (
            .clk(clk), .rst(rst), .en(en), .s_n(s_n), .r_n(r_n),
            .clr_cnt(clr_cnt), .q(q_o[g]), .q_n(qn_o[g]), .chg(chg_o[g]),
            .conflict(conf_o[g]), .conflict_mask(mask_o[g]),
            .conflict_cnt(cnt_o[g])
        );
    end

    typedef struct {
        string              tag;
        logic [NM-1:0][3:0] q;
        logic [NM-1:0]      chg;
        logic [NM-1:0]      conf;
        logic [NM-1:0][3:0] mask;
        logic [NM-1:0][1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state, one per mode.
    logic [3:0] m_q[NM];
    int         m_cnt[NM];

    task automatic chk(input string tag, input string nm, input int m,
                       input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s %s mode%0d: got %h, expected %h", tag, nm, m, act, exp);
        end
    endtask

    // Resolve one bit of the next state from the SR rules.
    function automatic logic model_bit(input int mode, input logic cur,
                                       input logic s, input logic r);
        if (s && r)   return cur;
        if (!s && r)  return 1'b1;
        if (s && !r)  return 1'b0;
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        if (mode == 3) return !cur;
        return cur;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input string tag, input logic r, input logic e,
                        input logic c, input logic [3:0] s, input logic [3:0] rr);
        exp_t x;
        logic [3:0] nq;
        int nconf;
        @(negedge clk);
        rst = r; en = e; clr_cnt = c; s_n = s; r_n = rr;
        x.tag = tag;
        for (int m = 0; m < NM; m++) begin
            if (r) begin
                nq = INIT;
                x.mask[m] = 4'h0;
                m_cnt[m] = 0;
                x.chg[m] = 1'b0;
            end else begin
                nq = m_q[m];
                nconf = 0;
                if (e) begin
                    for (int b = 0; b < 4; b++) begin
                        nq[b] = model_bit(m, m_q[m][b], s[b], rr[b]);
                        if (!s[b] && !rr[b]) nconf++;
                    end
                end
                x.mask[m] = e ? (~s & ~rr) : 4'h0;
                if (c) m_cnt[m] = 0;
                else if (nconf > 0 && m_cnt[m] < 3) m_cnt[m] = m_cnt[m] + 1;
                x.chg[m] = (nq != m_q[m]);
            end
            x.conf[m] = (x.mask[m] != 4'h0);
            x.q[m]    = nq;
            x.cnt[m]  = m_cnt[m][1:0];
            m_q[m]    = nq;
        end
        exp_q.push_back(x);
    endtask

    // Monitor: after each rising edge, compare the DUT with the oldest prediction.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                for (int m = 0; m < NM; m++) begin
                    chk(x.tag, "q", m, q_o[m], x.q[m]);
                    chk(x.tag, "q_n", m, qn_o[m], ~x.q[m]);
                    chk(x.tag, "chg", m, {3'b0, chg_o[m]}, {3'b0, x.chg[m]});
                    chk(x.tag, "conflict", m, {3'b0, conf_o[m]}, {3'b0, x.conf[m]});
                    chk(x.tag, "mask", m, mask_o[m], x.mask[m]);
                    chk(x.tag, "cnt", m, {2'b0, cnt_o[m]}, {2'b0, x.cnt[m]});
                end
            end
        end
    end

    initial begin
        int guard;
        logic r, e, c;
        logic [3:0] s, rr;
        for (int m = 0; m < NM; m++) begin
            m_q[m] = INIT;
            m_cnt[m] = 0;
        end

        // Reset and idle hold.
        step("reset", 1, 1, 0, 4'hF, 4'hF);
        step("idle1", 0, 1, 0, 4'hF, 4'hF);
        step("idle2", 0, 1, 0, 4'hF, 4'hF);
        // Plain set/reset and the following quiet cycle.
        step("setrst", 0, 1, 0, 4'b1110, 4'b1011);
        step("quiet", 0, 1, 0, 4'hF, 4'hF);
        // Forbidden input on bit0, starting from q=3.
        step("load3", 0, 1, 1, 4'b1100, 4'b0011);
        step("conf_mix", 0, 1, 0, 4'b1010, 4'b0110);
        step("load3b", 0, 1, 1, 4'b1100, 4'b0011);
        step("conf_b0", 0, 1, 0, 4'b1110, 4'b1110);
        // All-bits conflict held; toggling in MODE 3, then saturation.
        step("clear0", 0, 1, 1, 4'hF, 4'h0);
        for (int k = 0; k < 5; k++) step("conf_all", 0, 1, 0, 4'h0, 4'h0);
        step("clr_win", 0, 1, 1, 4'h0, 4'h0);
        step("en_off", 0, 0, 0, 4'h0, 4'h0);
        step("en_off2", 0, 0, 0, 4'h3, 4'hC);
        step("clr_en0", 0, 0, 1, 4'h0, 4'h0);
        // Reset collides with a set request.
        step("rst_mid", 1, 1, 0, 4'h0, 4'hF);
        step("post_rst", 0, 1, 0, 4'hF, 4'hF);

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            r  = ($urandom_range(0, 31) == 0);
            e  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 7) == 0);
            s  = 4'($urandom);
            rr = ($urandom_range(0, 1) == 0) ? (s | 4'($urandom)) : 4'($urandom);
            step("random", r, e, c, s, rr);
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
